// File: rtl/puf_ec_pkg.sv
// Shared constants, FSM state encoding and width helper for the PUF
// error-correction datapath.
package puf_ec_pkg;

  localparam int unsigned DEF_N       = 264;
  localparam int unsigned DEF_SYM     = 8;
  localparam int unsigned DEF_TIMEOUT = 1023;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_COLLECT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sym_popcount.sv
// Combinational population count over one decoder symbol.
module sym_popcount
  import puf_ec_pkg::*;
#(
  parameter  int unsigned SYM = DEF_SYM,
  localparam int unsigned PW  = clog2(SYM + 1)
) (
  input  logic [SYM-1:0] i_sym,
  output logic [PW-1:0]  o_cnt_c
);

  always_comb begin
    o_cnt_c = '0;
    for (int unsigned i = 0; i < SYM; i++) begin
      o_cnt_c = o_cnt_c + PW'(i_sym[i]);
    end
  end

endmodule

// File: rtl/ec_stream_ctrl.sv
// Streams the noisy codeword into an external BCH decoder symbol by symbol,
// reassembles the returned error symbols and emits the corrected response.
module ec_stream_ctrl
  import puf_ec_pkg::*;
#(
  parameter  int unsigned N       = DEF_N,
  parameter  int unsigned SYM     = DEF_SYM,
  parameter  int unsigned TIMEOUT = DEF_TIMEOUT,
  localparam int unsigned N_SYM   = N / SYM,
  localparam int unsigned WW      = clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   RplusC,
  input  logic [N-1:0]   response,
  output logic           busy,
  output logic [SYM-1:0] dec_data,
  output logic           dec_start,
  input  logic [SYM-1:0] err_in,
  input  logic           err_first,
  output logic [N-1:0]   corrected,
  output logic [WW-1:0]  err_weight,
  output logic           ready,
  output logic           fail
);

  localparam int unsigned CW = clog2(N_SYM + 1);
  localparam int unsigned TW = clog2(TIMEOUT + 1);
  localparam int unsigned PW = clog2(SYM + 1);

  logic [2:0]     r_state,     w_state_nxt;
  logic [CW-1:0]  r_sym_cnt,   w_sym_cnt_nxt;
  logic [TW-1:0]  r_tcnt,      w_tcnt_nxt;
  logic [N-1:0]   r_resp,      w_resp_nxt;
  logic [N-1:0]   r_cw,        w_cw_nxt;
  logic [N-1:0]   r_err,       w_err_nxt;
  logic [N-1:0]   r_corr,      w_corr_nxt;
  logic [WW-1:0]  r_weight,    w_weight_nxt;
  logic [SYM-1:0] r_dec_data,  w_dec_data_nxt;
  logic           r_dec_start, w_dec_start_nxt;
  logic           r_ready,     w_ready_nxt;
  logic           r_fail,      w_fail_nxt;
  logic           r_busy,      w_busy_nxt;

  logic [N-1:0]   w_cw_in;
  logic [CW-1:0]  w_sym_inc;
  logic [PW-1:0]  w_pop;

  assign w_cw_in   = RplusC ^ response;
  assign w_sym_inc = r_sym_cnt + CW'(1);

  sym_popcount #(.SYM(SYM)) u_pop (
    .i_sym   (err_in),
    .o_cnt_c (w_pop)
  );

  // Next-state and next-output logic; every output is a flop fed from here.
  always_comb begin
    w_state_nxt     = r_state;
    w_sym_cnt_nxt   = r_sym_cnt;
    w_tcnt_nxt      = r_tcnt;
    w_resp_nxt      = r_resp;
    w_cw_nxt        = r_cw;
    w_err_nxt       = r_err;
    w_corr_nxt      = r_corr;
    w_weight_nxt    = r_weight;
    w_fail_nxt      = r_fail;
    w_dec_data_nxt  = '0;
    w_dec_start_nxt = 1'b0;
    w_ready_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_resp_nxt      = response;
          w_cw_nxt        = w_cw_in;
          w_fail_nxt      = 1'b0;
          w_weight_nxt    = '0;
          w_err_nxt       = '0;
          w_sym_cnt_nxt   = '0;
          // Symbol 0 is presented in the first SEND cycle.
          w_dec_data_nxt  = w_cw_in[SYM-1:0];
          w_dec_start_nxt = 1'b1;
          w_state_nxt     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_sym_cnt == CW'(N_SYM - 1)) begin
          w_tcnt_nxt  = '0;
          w_state_nxt = ST_WAIT;
        end else begin
          w_sym_cnt_nxt  = w_sym_inc;
          w_dec_data_nxt = r_cw[SYM*w_sym_inc +: SYM];
        end
      end
      ST_WAIT: begin
        if (err_first) begin
          w_err_nxt[SYM-1:0] = err_in;
          w_weight_nxt       = r_weight + WW'(w_pop);
          w_sym_cnt_nxt      = CW'(1);
          w_state_nxt        = ST_COLLECT;
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_corr_nxt  = r_resp;
          w_fail_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      ST_COLLECT: begin
        w_err_nxt[SYM*r_sym_cnt +: SYM] = err_in;
        w_weight_nxt = r_weight + WW'(w_pop);
        if (r_sym_cnt == CW'(N_SYM - 1)) begin
          w_corr_nxt  = r_resp ^ w_err_nxt;
          w_ready_nxt = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_sym_cnt_nxt = w_sym_inc;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sym_cnt   <= '0;
      r_tcnt      <= '0;
      r_resp      <= '0;
      r_cw        <= '0;
      r_err       <= '0;
      r_corr      <= '0;
      r_weight    <= '0;
      r_dec_data  <= '0;
      r_dec_start <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sym_cnt   <= w_sym_cnt_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_resp      <= w_resp_nxt;
      r_cw        <= w_cw_nxt;
      r_err       <= w_err_nxt;
      r_corr      <= w_corr_nxt;
      r_weight    <= w_weight_nxt;
      r_dec_data  <= w_dec_data_nxt;
      r_dec_start <= w_dec_start_nxt;
      r_ready     <= w_ready_nxt;
      r_fail      <= w_fail_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign busy       = r_busy;
  assign dec_data   = r_dec_data;
  assign dec_start  = r_dec_start;
  assign corrected  = r_corr;
  assign err_weight = r_weight;
  assign ready      = r_ready;
  assign fail       = r_fail;

endmodule

// File: tb/tb_ec_stream_ctrl.sv
// Directed bench: a small 24-bit instance driven from a vector table plus
// hand sequences, and a default-size instance run back-to-back.
module tb_ec_stream_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Small instance: N=24, SYM=8, TIMEOUT=15
  logic        s_start, s_busy, s_ds, s_ef, s_rdy, s_fail;
  logic [23:0] s_rpc, s_resp, s_corr;
  logic [7:0]  s_dd, s_ein;
  logic [4:0]  s_w;

  // Default instance: N=264, SYM=8, TIMEOUT=1023
  logic         d_start, d_busy, d_ds, d_ef, d_rdy, d_fail;
  logic [263:0] d_rpc, d_resp, d_corr;
  logic [7:0]   d_dd, d_ein;
  logic [8:0]   d_w;

  ec_stream_ctrl #(.N(24), .SYM(8), .TIMEOUT(15)) u_small (
    .clk        (clk),
    .rst        (rst),
    .start      (s_start),
    .RplusC     (s_rpc),
    .response   (s_resp),
    .busy       (s_busy),
    .dec_data   (s_dd),
    .dec_start  (s_ds),
    .err_in     (s_ein),
    .err_first  (s_ef),
    .corrected  (s_corr),
    .err_weight (s_w),
    .ready      (s_rdy),
    .fail       (s_fail)
  );

  ec_stream_ctrl u_dflt (
    .clk        (clk),
    .rst        (rst),
    .start      (d_start),
    .RplusC     (d_rpc),
    .response   (d_resp),
    .busy       (d_busy),
    .dec_data   (d_dd),
    .dec_start  (d_ds),
    .err_in     (d_ein),
    .err_first  (d_ef),
    .corrected  (d_corr),
    .err_weight (d_w),
    .ready      (d_rdy),
    .fail       (d_fail)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [23:0] prev_corr;

  typedef struct {
    logic [23:0] rplusc;
    logic [23:0] resp;
    logic [7:0]  e0, e1, e2;
    int          wdly;      // WAIT cycles before err_first; -1 = never
    bit          stray;
    logic [23:0] exp_cw;
    logic [23:0] exp_corr;
    int          exp_w;
    bit          exp_fail;
    int          exp_rdy;   // cycle of ready, counted from the start edge
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_small(input vec_t v);
    int budget;
    s_rpc   = v.rplusc;
    s_resp  = v.resp;
    s_start = 1'b1;
    cyc     = 0;
    tick();
    s_start = 1'b0;
    check("s_busy_go",   264'(s_busy), 264'(1'b1));
    check("s_fail_clr",  264'(s_fail), 264'(1'b0));
    check("s_corr_kept", 264'(s_corr), 264'(prev_corr));
    check("s_wt_clr",    264'(s_w),    264'(0));
    for (int k = 0; k < 3; k++) begin
      check("s_dec_data",  264'(s_dd), 264'(v.exp_cw[8*k +: 8]));
      check("s_dec_start", 264'(s_ds), 264'(k == 0));
      if (v.stray && k == 1) begin
        s_start = 1'b1;
        s_ef    = 1'b1;
        s_ein   = 8'hFF;
      end
      tick();
      s_start = 1'b0;
      s_ef    = 1'b0;
      s_ein   = 8'h00;
    end
    check("s_dec_idle", 264'({s_ds, s_dd}), 264'(0));
    if (v.wdly >= 0) begin
      repeat (v.wdly) tick();
      s_ef  = 1'b1;
      s_ein = v.e0;
      tick();
      s_ef  = 1'b0;
      s_ein = v.e1;
      if (v.stray) s_start = 1'b1;
      tick();
      s_start = 1'b0;
      s_ein   = v.e2;
      tick();
      s_ein = 8'h00;
    end
    budget = 40;
    while (!s_rdy && budget > 0) begin
      tick();
      budget--;
    end
    check("s_ready_cyc", 264'(cyc),    264'(v.exp_rdy));
    check("s_ready",     264'(s_rdy),  264'(1'b1));
    check("s_corrected", 264'(s_corr), 264'(v.exp_corr));
    check("s_weight",    264'(s_w),    264'(v.exp_w));
    check("s_fail",      264'(s_fail), 264'(v.exp_fail));
    prev_corr = v.exp_corr;
    tick();
    check("s_ready_once", 264'({s_rdy, s_busy}), 264'(0));
    check("s_corr_hold",  264'(s_corr), 264'(v.exp_corr));
    check("s_fail_hold",  264'(s_fail), 264'(v.exp_fail));
  endtask

  task automatic run_dflt(input logic [263:0] rp, input logic [263:0] rs, input logic [263:0] er);
    logic [263:0] cw;
    int budget;
    cw      = rp ^ rs;
    d_rpc   = rp;
    d_resp  = rs;
    d_start = 1'b1;
    cyc     = 0;
    tick();
    d_start = 1'b0;
    for (int k = 0; k < 33; k++) begin
      check("d_dec_data",  264'(d_dd), 264'(cw[8*k +: 8]));
      check("d_dec_start", 264'(d_ds), 264'(k == 0));
      tick();
    end
    repeat (3) tick();
    d_ef = 1'b1;
    for (int k = 0; k < 33; k++) begin
      d_ein = er[8*k +: 8];
      tick();
      d_ef = 1'b0;
    end
    d_ein  = 8'h00;
    budget = 10;
    while (!d_rdy && budget > 0) begin
      tick();
      budget--;
    end
    check("d_ready_cyc", 264'(cyc),    264'(70));
    check("d_corrected", d_corr,       rs ^ er);
    check("d_weight",    264'(d_w),    264'($countones(er)));
    check("d_fail",      264'(d_fail), 264'(1'b0));
    tick();
    check("d_ready_once", 264'(d_rdy), 264'(1'b0));
  endtask

  task automatic rand_vec(output logic [263:0] v);
    for (int i = 0; i < 33; i++) v[8*i +: 8] = 8'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [263:0] rp, rs, er;
    int  nbits;
    bit  saw_ready;

    vecs[0] = '{rplusc:24'hA5A5A5, resp:24'h0F0F0F, e0:8'h00, e1:8'h00, e2:8'h00,
                wdly:2, stray:1'b0, exp_cw:24'hAAAAAA, exp_corr:24'h0F0F0F,
                exp_w:0, exp_fail:1'b0, exp_rdy:9};
    vecs[1] = '{rplusc:24'h000000, resp:24'h123456, e0:8'h01, e1:8'h80, e2:8'h03,
                wdly:0, stray:1'b0, exp_cw:24'h123456, exp_corr:24'h11B457,
                exp_w:4, exp_fail:1'b0, exp_rdy:7};
    vecs[2] = '{rplusc:24'hFFFFFF, resp:24'h0000FF, e0:8'h00, e1:8'h00, e2:8'h00,
                wdly:-1, stray:1'b0, exp_cw:24'hFFFF00, exp_corr:24'h0000FF,
                exp_w:0, exp_fail:1'b1, exp_rdy:19};
    vecs[3] = '{rplusc:24'h0000FF, resp:24'h800001, e0:8'h80, e1:8'h00, e2:8'h80,
                wdly:5, stray:1'b0, exp_cw:24'h8000FE, exp_corr:24'h000081,
                exp_w:2, exp_fail:1'b0, exp_rdy:12};
    vecs[4] = '{rplusc:24'h5A5A5A, resp:24'hC3C3C3, e0:8'hFF, e1:8'h00, e2:8'h10,
                wdly:1, stray:1'b1, exp_cw:24'h999999, exp_corr:24'hD3C33C,
                exp_w:9, exp_fail:1'b0, exp_rdy:8};

    rst     = 1'b1;
    s_start = 1'b0; s_rpc = '0; s_resp = '0; s_ein = '0; s_ef = 1'b0;
    d_start = 1'b0; d_rpc = '0; d_resp = '0; d_ein = '0; d_ef = 1'b0;
    prev_corr = '0;
    repeat (3) tick();
    check("s_reset_ctl",  264'({s_busy, s_dd, s_ds, s_rdy, s_fail, s_w}), 264'(0));
    check("s_reset_corr", 264'(s_corr), 264'(0));
    check("d_reset_ctl",  264'({d_busy, d_dd, d_ds, d_rdy, d_fail, d_w}), 264'(0));
    check("d_reset_corr", d_corr, 264'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_small(vecs[i]);

    // Reset while collecting error symbols aborts the run with no ready.
    s_rpc   = 24'h000000;
    s_resp  = 24'h123456;
    s_start = 1'b1;
    cyc     = 0;
    tick();
    s_start = 1'b0;
    repeat (3) tick();
    s_ef  = 1'b1;
    s_ein = 8'h01;
    tick();
    s_ef  = 1'b0;
    s_ein = 8'h80;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    s_ein = 8'h00;
    check("s_rst_mid_ctl",  264'({s_busy, s_dd, s_ds, s_rdy, s_fail, s_w}), 264'(0));
    check("s_rst_mid_corr", 264'(s_corr), 264'(0));
    saw_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_rdy) saw_ready = 1'b1;
    end
    check("s_rst_no_ready", 264'(saw_ready), 264'(1'b0));
    prev_corr = '0;
    run_small(vecs[1]);

    // Default size, two runs back-to-back with sparse random error patterns.
    for (int r = 0; r < 2; r++) begin
      rand_vec(rp);
      rand_vec(rs);
      er    = '0;
      nbits = int'($urandom_range(1, 8));
      while ($countones(er) < nbits) er[$urandom_range(0, 263)] = 1'b1;
      run_dflt(rp, rs, er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
